control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Main decoder of the single-issue scalar/vector ASIP. Maps the 4-bit opcode of the current
//  instruction to the datapath control strobes: PC, scalar/vector regfiles, ALUs, data memory.
//  Decode is combinational, zero latency. A one-bit equality flag register, written by CMP,
//  resolves the conditional branch JEQ.
// PARAMETERS
//  OPW   4   opcode width (fixed; other values unsupported)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  opcode       in   4  opcode of current instruction
//  zero         in   1  scalar ALU zero result (valid during CMP)
//  mux_pc       out  1  PC source select: 0 = PC+1, 1 = branch target
//  pc_en        out  1  PC register update enable
//  sca_reg_w    out  1  scalar regfile write enable
//  vec_reg_w    out  1  vector regfile write enable
//  sca_mux_exe  out  1  scalar ALU operand B select: 0 = register, 1 = immediate
//  sca_alu_op   out  1  scalar ALU op: 0 = add, 1 = subtract
//  vec_alu_op   out  1  vector ALU op: 0 = lane add, 1 = lane fixed-point multiply
//  w_mem        out  1  data memory write enable
//  r_mem        out  1  data memory read enable
//  sca_reg_wd   out  1  scalar writeback select: 0 = ALU, 1 = memory
//  vec_reg_wd   out  1  vector writeback select: 0 = ALU, 1 = memory
//  vec_reg_wfp  out  1  vector writeback takes fixed-point-rescaled product
// BEHAVIOUR
//  Clocking and reset:
//  - Single clock domain; rst is asynchronous, active-high (fixed).
//  - While rst=1: every output is 0, including pc_en; eq_flag is cleared to 0.
//  - Outputs are combinational from opcode and eq_flag; no pipeline latency.
//  - Any output not listed for an opcode below is 0. pc_en=1 for every opcode when rst=0.
//  Opcode decode:
//  - 0000 SUM   : sca_reg_w
//  - 0001 SUB   : sca_reg_w, sca_alu_op
//  - 0010 SUMI  : sca_reg_w, sca_mux_exe
//  - 0011 MULFV : vec_reg_w, vec_alu_op, vec_reg_wfp
//  - 0100 SUMV  : vec_reg_w
//  - 0101 LDV   : vec_reg_w, r_mem, vec_reg_wd
//  - 0110 CMP   : sca_alu_op (no regfile write); on the rising clk edge, eq_flag <= zero
//  - 0111 NOP   : pc_en only
//  - 1000 STV   : w_mem
//  - 1001 JEQ   : mux_pc = eq_flag
//  - 1010 JMP   : mux_pc = 1
//  - 1011 LDR   : sca_reg_w, sca_mux_exe, r_mem, sca_reg_wd
//  - 1100 STR   : w_mem, sca_mux_exe
//  - 1101-1111  : reserved; decoded exactly as NOP
//  - opcode containing X/Z: decoded as NOP; eq_flag unchanged.
//  eq_flag rules:
//  - eq_flag changes only on a CMP cycle; all other opcodes hold it.
//  - JEQ uses the eq_flag of the most recent CMP, any number of cycles earlier.
//  - zero is ignored outside CMP cycles.
//  - rst asserted mid-sequence clears eq_flag, so a JEQ after reset falls through (mux_pc=0).
//  Invariants:
//  - w_mem and r_mem are never both 1.
//  - sca_reg_w and vec_reg_w are never both 1.
// TESTING
//  - rst=1, any opcode -> all outputs 0; release rst, opcode=0111 -> pc_en=1, all else 0.
//  - opcode=0000 -> sca_reg_w=1, pc_en=1; opcode=0010 -> adds sca_mux_exe=1; all else 0.
//  - CMP (0110) with zero=1, clk edge, then JEQ (1001) -> mux_pc=1, pc_en=1, no writes.
//  - CMP with zero=0, clk edge, then JEQ -> mux_pc=0; NOP in between leaves result unchanged.
//  - opcode=0011 -> vec_reg_w=1, vec_alu_op=1, vec_reg_wfp=1, pc_en=1; scalar strobes and mem 0.
//  - CMP zero=1 then rst pulse, then JEQ -> mux_pc=0; opcodes 1101/1111 -> identical to NOP.

Source files
------------

// File: rtl/control_unit.sv
// Main instruction decoder for the scalar/vector ASIP: combinational opcode-to-strobe decode
// plus the CMP-written equality flag that resolves JEQ.
module control_unit #(
    parameter int unsigned OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           mux_pc,
    output logic           pc_en,
    output logic           sca_reg_w,
    output logic           vec_reg_w,
    output logic           sca_mux_exe,
    output logic           sca_alu_op,
    output logic           vec_alu_op,
    output logic           w_mem,
    output logic           r_mem,
    output logic           sca_reg_wd,
    output logic           vec_reg_wd,
    output logic           vec_reg_wfp
);

    typedef enum logic [3:0] {
        OpSum   = 4'b0000,
        OpSub   = 4'b0001,
        OpSumi  = 4'b0010,
        OpMulfv = 4'b0011,
        OpSumv  = 4'b0100,
        OpLdv   = 4'b0101,
        OpCmp   = 4'b0110,
        OpNop   = 4'b0111,
        OpStv   = 4'b1000,
        OpJeq   = 4'b1001,
        OpJmp   = 4'b1010,
        OpLdr   = 4'b1011,
        OpStr   = 4'b1100
    } opcode_e;

    logic eq_flag_q, eq_flag_d;

    // An opcode with X/Z bits fails the equality, so the flag holds.
    always_comb begin
        eq_flag_d = eq_flag_q;
        if (opcode == OpCmp) begin
            eq_flag_d = zero;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_flag_q <= 1'b0;
        end else begin
            eq_flag_q <= eq_flag_d;
        end
    end

    always_comb begin
        mux_pc      = 1'b0;
        pc_en       = 1'b0;
        sca_reg_w   = 1'b0;
        vec_reg_w   = 1'b0;
        sca_mux_exe = 1'b0;
        sca_alu_op  = 1'b0;
        vec_alu_op  = 1'b0;
        w_mem       = 1'b0;
        r_mem       = 1'b0;
        sca_reg_wd  = 1'b0;
        vec_reg_wd  = 1'b0;
        vec_reg_wfp = 1'b0;
        if (!rst) begin
            pc_en = 1'b1;
            // Reserved and unknown opcodes fall to default and behave as NOP.
            case (opcode)
                OpSum: sca_reg_w = 1'b1;
                OpSub: begin
                    sca_reg_w  = 1'b1;
                    sca_alu_op = 1'b1;
                end
                OpSumi: begin
                    sca_reg_w   = 1'b1;
                    sca_mux_exe = 1'b1;
                end
                OpMulfv: begin
                    vec_reg_w   = 1'b1;
                    vec_alu_op  = 1'b1;
                    vec_reg_wfp = 1'b1;
                end
                OpSumv: vec_reg_w = 1'b1;
                OpLdv: begin
                    vec_reg_w  = 1'b1;
                    r_mem      = 1'b1;
                    vec_reg_wd = 1'b1;
                end
                OpCmp: sca_alu_op = 1'b1;
                OpStv: w_mem = 1'b1;
                OpJeq: mux_pc = eq_flag_q;
                OpJmp: mux_pc = 1'b1;
                OpLdr: begin
                    sca_reg_w   = 1'b1;
                    sca_mux_exe = 1'b1;
                    r_mem       = 1'b1;
                    sca_reg_wd  = 1'b1;
                end
                OpStr: begin
                    w_mem       = 1'b1;
                    sca_mux_exe = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode table, CMP/JEQ flag behaviour and reset.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic mux_pc, pc_en, sca_reg_w, vec_reg_w, sca_mux_exe, sca_alu_op;
    logic vec_alu_op, w_mem, r_mem, sca_reg_wd, vec_reg_wd, vec_reg_wfp;

    int n_checks = 0;
    int n_fails  = 0;

    // Strobe vector bit masks, MSB first: mux_pc .. vec_reg_wfp
    localparam logic [11:0] MUX = 12'b1000_0000_0000;
    localparam logic [11:0] PCE = 12'b0100_0000_0000;
    localparam logic [11:0] SRW = 12'b0010_0000_0000;
    localparam logic [11:0] VRW = 12'b0001_0000_0000;
    localparam logic [11:0] SMX = 12'b0000_1000_0000;
    localparam logic [11:0] SAO = 12'b0000_0100_0000;
    localparam logic [11:0] VAO = 12'b0000_0010_0000;
    localparam logic [11:0] WM  = 12'b0000_0001_0000;
    localparam logic [11:0] RM  = 12'b0000_0000_1000;
    localparam logic [11:0] SWD = 12'b0000_0000_0100;
    localparam logic [11:0] VWD = 12'b0000_0000_0010;
    localparam logic [11:0] VFP = 12'b0000_0000_0001;

    logic [11:0] exp_tab [16];

    control_unit #(.OPW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .zero        (zero),
        .mux_pc      (mux_pc),
        .pc_en       (pc_en),
        .sca_reg_w   (sca_reg_w),
        .vec_reg_w   (vec_reg_w),
        .sca_mux_exe (sca_mux_exe),
        .sca_alu_op  (sca_alu_op),
        .vec_alu_op  (vec_alu_op),
        .w_mem       (w_mem),
        .r_mem       (r_mem),
        .sca_reg_wd  (sca_reg_wd),
        .vec_reg_wd  (vec_reg_wd),
        .vec_reg_wfp (vec_reg_wfp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {mux_pc, pc_en, sca_reg_w, vec_reg_w, sca_mux_exe, sca_alu_op,
                vec_alu_op, w_mem, r_mem, sca_reg_wd, vec_reg_wd, vec_reg_wfp};
    endfunction

    task automatic check(input string tag, input logic [11:0] expv);
        logic [11:0] obs;
        obs = outs();
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Drive away from the active edge, settle, then the caller checks.
    task automatic step(input logic [3:0] op, input logic z);
        @(negedge clk);
        opcode = op;
        zero   = z;
        #1;
    endtask

    initial begin
        exp_tab[0]  = PCE | SRW;
        exp_tab[1]  = PCE | SRW | SAO;
        exp_tab[2]  = PCE | SRW | SMX;
        exp_tab[3]  = PCE | VRW | VAO | VFP;
        exp_tab[4]  = PCE | VRW;
        exp_tab[5]  = PCE | VRW | RM | VWD;
        exp_tab[6]  = PCE | SAO;
        exp_tab[7]  = PCE;
        exp_tab[8]  = PCE | WM;
        exp_tab[9]  = PCE;          // eq_flag is 0 here
        exp_tab[10] = PCE | MUX;
        exp_tab[11] = PCE | SRW | SMX | RM | SWD;
        exp_tab[12] = PCE | WM | SMX;
        exp_tab[13] = PCE;
        exp_tab[14] = PCE;
        exp_tab[15] = PCE;

        rst    = 1'b1;
        opcode = 4'b0000;
        zero   = 1'b1;
        step(4'b0000, 1'b1);
        check("reset_sum", 12'h000);
        step(4'b1010, 1'b1);
        check("reset_jmp", 12'h000);
        step(4'b0110, 1'b1);
        check("reset_cmp", 12'h000);

        @(negedge clk);
        rst = 1'b0;
        step(4'b0111, 1'b0);
        check("nop_after_reset", PCE);

        // Full decode sweep with zero=0, so the CMP step keeps the flag at 0
        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b0);
            check($sformatf("decode_%b", 4'(i)), exp_tab[i]);
            check_bit($sformatf("mem_excl_%b", 4'(i)), w_mem & r_mem, 1'b0);
            check_bit($sformatf("rf_excl_%b", 4'(i)), sca_reg_w & vec_reg_w, 1'b0);
        end

        step(4'b0110, 1'b1);
        check("cmp_z1", PCE | SAO);
        step(4'b1001, 1'b0);
        check("jeq_taken", PCE | MUX);
        step(4'b0111, 1'b0);
        check("nop_hold", PCE);
        step(4'b0000, 1'b0);
        check("sum_hold", PCE | SRW);
        step(4'b1001, 1'b0);
        check("jeq_still_taken", PCE | MUX);

        step(4'b0110, 1'b0);
        check("cmp_z0", PCE | SAO);
        step(4'b0111, 1'b1);
        check("nop_zero_ignored", PCE);
        step(4'b1001, 1'b1);
        check("jeq_not_taken", PCE);

        step(4'b0110, 1'b1);
        step(4'b1001, 1'b0);
        check("jeq_taken_again", PCE | MUX);
        // Asynchronous reset pulse mid-cycle clears the flag
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 12'h000);
        #1;
        rst = 1'b0;
        #1;
        check("jeq_after_reset", PCE);
        step(4'b1001, 1'b0);
        check("jeq_after_reset_edge", PCE);

        step(4'b1101, 1'b0);
        check("reserved_1101", PCE);
        step(4'b1111, 1'b0);
        check("reserved_1111", PCE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
